chacha_ks_prefetch: RTL and testbench

Parametrised ChaCha keystream prefetch engine. It owns one `chacha_core` and generates successive 512-bit keystream blocks ahead of demand into a DEPTH-block buffer. It serves the keystream as OUT_W-bit slices over a valid/ready stream. It sits between the configuration registers and the ChaCha20 XOR datapath, replacing single-block request/response keystream generation.

---
 rtl/chacha_ks_prefetch_if.sv | 17 +
 rtl/chacha_ks_prefetch.sv | 270 +++++++++++++++++++++++++++
 tb/tb_chacha_ks_prefetch.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chacha_ks_prefetch_if.sv
`default_nettype none
//==============================================================================
// Module   : chacha_ks_prefetch_if
// Brief    : Keystream slice stream (valid/ready) between prefetcher and consumer.
// Revision : 1.0 - initial release
//==============================================================================
interface chacha_ks_prefetch_if #(
    parameter int OUT_W = 128
) ();
    logic             ks_valid;
    logic             ks_ready;
    logic [OUT_W-1:0] ks_data;

    modport master (output ks_valid, output ks_data, input ks_ready);
    modport slave  (input ks_valid, input ks_data, output ks_ready);
endinterface
`default_nettype wire

// File: rtl/chacha_ks_prefetch.sv
`default_nettype none
//==============================================================================
// Module   : chacha_ks_prefetch (+ chacha_core)
// Brief    : ChaCha20 keystream prefetcher; optional CHACHA_KS_WRAP_STOP_EN halts
//            issue after the block with counter 0xFFFFFFFF.
// Revision : 1.0 - initial release
//==============================================================================
module chacha_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init_i,
    input  logic [255:0] key_i,
    input  logic [63:0]  ctr_i,
    input  logic [63:0]  iv_i,
    input  logic [511:0] data_in_i,
    output logic         ready_o,
    output logic [511:0] data_out_o,
    output logic         data_out_valid_o
);
    typedef logic [15:0][31:0] st_t;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic st_t qstep(input st_t s, input logic [3:0] a, b, c, d);
        logic [127:0] r;
        r    = qr(s[a], s[b], s[c], s[d]);
        s[a] = r[127:96];
        s[b] = r[95:64];
        s[c] = r[63:32];
        s[d] = r[31:0];
        return s;
    endfunction

    function automatic st_t dround(input st_t s);
        s = qstep(s, 4'd0, 4'd4, 4'd8,  4'd12);
        s = qstep(s, 4'd1, 4'd5, 4'd9,  4'd13);
        s = qstep(s, 4'd2, 4'd6, 4'd10, 4'd14);
        s = qstep(s, 4'd3, 4'd7, 4'd11, 4'd15);
        s = qstep(s, 4'd0, 4'd5, 4'd10, 4'd15);
        s = qstep(s, 4'd1, 4'd6, 4'd11, 4'd12);
        s = qstep(s, 4'd2, 4'd7, 4'd8,  4'd13);
        s = qstep(s, 4'd3, 4'd4, 4'd9,  4'd14);
        return s;
    endfunction

    st_t          x_q, s_q, w_init;
    logic [3:0]   cnt_q;
    logic         busy_q, valid_q;
    logic [511:0] data_q, w_blk;

    // Bus fields are big-endian byte strings; state words are little-endian.
    assign w_init[0]  = 32'h61707865;
    assign w_init[1]  = 32'h3320646e;
    assign w_init[2]  = 32'h79622d32;
    assign w_init[3]  = 32'h6b206574;
    assign w_init[12] = ctr_i[63:32];
    assign w_init[13] = bswap(iv_i[63:32]);
    assign w_init[14] = bswap(iv_i[31:0]);
    assign w_init[15] = bswap(ctr_i[31:0]);

    for (genvar i = 0; i < 8; i++) begin : g_key
        assign w_init[4+i] = bswap(key_i[255-32*i -: 32]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ser
        assign w_blk[511-32*i -: 32] = bswap(x_q[i] + s_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            s_q     <= '0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (busy_q) begin
                if (cnt_q == 4'd10) begin
                    data_q  <= w_blk ^ data_in_i;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                end else begin
                    x_q   <= dround(x_q);
                    cnt_q <= cnt_q + 4'd1;
                end
            end else if (init_i) begin
                x_q    <= w_init;
                s_q    <= w_init;
                cnt_q  <= 4'd0;
                busy_q <= 1'b1;
            end
        end
    end

    assign ready_o          = !busy_q;
    assign data_out_o       = data_q;
    assign data_out_valid_o = valid_q;
endmodule

module chacha_ks_prefetch #(
    parameter int DEPTH = 4,
    parameter int OUT_W = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chacha_ks_prefetch_if.master   ks,
    input  logic [255:0]           chacha_key_i,
    input  logic [95:0]            chacha_nonce_i,
    input  logic [31:0]            chacha_ctr_init_i,
    input  logic                   cfg_we_i,
    input  logic                   enable_i,
    output logic [$clog2(DEPTH):0] fill_level_o,
    output logic [31:0]            ctr_cur_o,
    output logic                   ctr_wrap_o
);
    localparam int NSL = 512 / OUT_W;
    localparam int SW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int FW  = PW + 1;
`ifdef CHACHA_KS_WRAP_STOP_EN
    localparam bit WRAP_STOP = 1'b1;
`else
    localparam bit WRAP_STOP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state_q;
    logic          init_q, wrap_q, drop_q, cfg_ok_q;
    logic [255:0]  key_q;
    logic [95:0]   nonce_q;
    logic [31:0]   ctr_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [SW-1:0] sl_q;
    logic [FW-1:0] fill_q, fill_d;
    logic [511:0]  mem_q [DEPTH];

    logic          w_core_ready, w_core_valid;
    logic [511:0]  w_core_data, w_head_sh;
    logic          w_valid, w_fire, w_last, w_wr, w_can_issue, w_drop_cfg;
    logic [FW:0]   w_occupancy;

    chacha_core u_core (
        .clk              (clk),
        .rst_n            (rst_n),
        .init_i           (init_q),
        .key_i            (key_q),
        .ctr_i            ({ctr_q, nonce_q[31:0]}),
        .iv_i             (nonce_q[95:32]),
        .data_in_i        (512'd0),
        .ready_o          (w_core_ready),
        .data_out_o       (w_core_data),
        .data_out_valid_o (w_core_valid)
    );

    assign w_valid     = (fill_q != '0);
    assign w_fire      = w_valid && ks.ks_ready;
    assign w_last      = w_fire && (sl_q == SW'(NSL - 1));
    assign w_wr        = w_core_valid && !drop_q;
    assign w_occupancy = {1'b0, fill_q} + (FW+1)'(state_q != S_IDLE);
    assign w_can_issue = enable_i && w_core_ready && (w_occupancy < (FW+1)'(DEPTH))
                         && !wrap_q && !drop_q && cfg_ok_q;
    // A block still owed by the core after a flush must be swallowed, not stored.
    assign w_drop_cfg  = (state_q == S_ISSUE)
                         || (((state_q == S_WAIT) || drop_q) && !w_core_valid);

    always_comb begin
        fill_d = fill_q;
        if (w_wr && !w_last)
            fill_d = fill_q + FW'(1);
        else if (!w_wr && w_last)
            fill_d = fill_q - FW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            init_q   <= 1'b0;
            wrap_q   <= 1'b0;
            drop_q   <= 1'b0;
            cfg_ok_q <= 1'b0;
            key_q    <= '0;
            nonce_q  <= '0;
            ctr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sl_q     <= '0;
            fill_q   <= '0;
        end else if (cfg_we_i) begin
            state_q  <= S_IDLE;
            init_q   <= 1'b0;
            wrap_q   <= 1'b0;
            drop_q   <= w_drop_cfg;
            cfg_ok_q <= 1'b1;
            key_q    <= chacha_key_i;
            nonce_q  <= chacha_nonce_i;
            ctr_q    <= chacha_ctr_init_i;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sl_q     <= '0;
            fill_q   <= '0;
        end else begin
            fill_q <= fill_d;
            if (w_wr)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_last) begin
                sl_q     <= '0;
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end else if (w_fire) begin
                sl_q <= sl_q + SW'(1);
            end
            if (drop_q && w_core_valid)
                drop_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_can_issue) begin
                        state_q <= S_ISSUE;
                        init_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    init_q  <= 1'b0;
                    ctr_q   <= ctr_q + 32'd1;
                    state_q <= S_WAIT;
                    if (WRAP_STOP && (ctr_q == 32'hFFFF_FFFF))
                        wrap_q <= 1'b1;
                end
                S_WAIT: begin
                    if (w_core_valid)
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    init_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !cfg_we_i)
            mem_q[wr_ptr_q] <= w_core_data;
    end

    // MSB-first slicing: shift the head block so slice k lands in the top bits.
    assign w_head_sh   = mem_q[rd_ptr_q] << (OUT_W * sl_q);
    assign ks.ks_valid = w_valid;
    assign ks.ks_data  = w_valid ? w_head_sh[511 -: OUT_W] : '0;

    assign fill_level_o = fill_q;
    assign ctr_cur_o    = ctr_q;
    assign ctr_wrap_o   = wrap_q;
endmodule
`default_nettype wire

// File: tb/tb_chacha_ks_prefetch.sv
`default_nettype none
//==============================================================================
// Module   : tb_chacha_ks_prefetch
// Brief    : Randomised self-checking bench with an RFC-style ChaCha20 model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_chacha_ks_prefetch;
    localparam int DEPTH = 4;
    localparam int OUT_W = 128;
    localparam int NSL   = 512 / OUT_W;
    localparam logic [255:0] RFC_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [95:0]  RFC_NONCE = 96'h000000090000004a00000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chacha_ks_prefetch_if #(.OUT_W(OUT_W)) ks_if ();

    logic [255:0]            key;
    logic [95:0]             nonce;
    logic [31:0]             ctr_init;
    logic                    cfg_we, enable;
    logic [$clog2(DEPTH):0]  fill;
    logic [31:0]             ctr_cur;
    logic                    ctr_wrap;

    chacha_ks_prefetch #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ks                (ks_if),
        .chacha_key_i      (key),
        .chacha_nonce_i    (nonce),
        .chacha_ctr_init_i (ctr_init),
        .cfg_we_i          (cfg_we),
        .enable_i          (enable),
        .fill_level_o      (fill),
        .ctr_cur_o         (ctr_cur),
        .ctr_wrap_o        (ctr_wrap)
    );

    int checks = 0;
    int failures = 0;
    int cfg_gen = 0;
    int slices_rx = 0;
    int blocks_rx = 0;

    // ---------------- reference model (RFC 8439 block function) ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] le32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [127:0] qround(input logic [31:0] a, b, c, d);
        a += b; d = rotl(d ^ a, 16);
        c += d; b = rotl(b ^ c, 12);
        a += b; d = rotl(d ^ a, 8);
        c += d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [95:0] n,
                                                  input logic [31:0] c);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [511:0] o;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = le32(k[255-32*i -: 32]);
        s[12] = c;
        s[13] = le32(n[95:64]);
        s[14] = le32(n[63:32]);
        s[15] = le32(n[31:0]);
        x = s;
        for (int r = 0; r < 10; r++) begin
            {x[0], x[4], x[8],  x[12]} = qround(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qround(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qround(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qround(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qround(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qround(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qround(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qround(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) o[511-32*i -: 32] = le32(x[i] + s[i]);
        return o;
    endfunction

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follows every delivered slice against the model stream ctr_init, ctr_init+1, ...
    task automatic run_monitor();
        int           seen = 0;
        int           k = 0;
        logic [31:0]  ectr = '0;
        logic [511:0] eblk = '0;
        logic         hold = 1'b0;
        logic         fresh;
        logic [OUT_W-1:0] hdata = '0;
        forever begin
            @(negedge clk);
            fresh = (seen != cfg_gen);
            if (fresh) begin
                seen = cfg_gen;
                ectr = ctr_init;
                k    = 0;
                eblk = chacha_block(key, nonce, ectr);
            end
            check("valid_vs_fill", ks_if.ks_valid, fill != 0);
            check("fill_bound", fill <= DEPTH, 1);
            if (hold && !fresh) begin
                check("hold_valid", ks_if.ks_valid, 1);
                check("hold_data", ks_if.ks_data, hdata);
            end
            if (ks_if.ks_valid && ks_if.ks_ready) begin
                check("slice", ks_if.ks_data, eblk[511-k*OUT_W -: OUT_W]);
                slices_rx++;
                k++;
                if (k == NSL) begin
                    k = 0;
                    ectr = ectr + 32'd1;
                    blocks_rx++;
                    eblk = chacha_block(key, nonce, ectr);
                end
            end
            hold  = !fresh && ks_if.ks_valid && !ks_if.ks_ready;
            hdata = ks_if.ks_data;
        end
    endtask

    task automatic do_cfg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        key = k; nonce = n; ctr_init = c;
        ks_if.ks_ready = 1'b0;
        cfg_we = 1'b1;
        cfg_gen++;
        tick();
        cfg_we = 1'b0;
        @(negedge clk);
        check("cfg_fill_zero", fill, 0);
        check("cfg_valid_zero", ks_if.ks_valid, 0);
        tick();
    endtask

    task automatic random_ready_until_blocks(input int target, input int budget);
        int n = 0;
        while (blocks_rx < target && n < budget) begin
            ks_if.ks_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ks_if.ks_ready = 1'b0;
        check("blocks_within_budget", blocks_rx >= target, 1);
    endtask

    initial begin
        logic [511:0] blk;
        int n, b0, s0;
        cfg_we = 1'b0; enable = 1'b0; key = '0; nonce = '0; ctr_init = '0;
        ks_if.ks_ready = 1'b0;
        fork
            run_monitor();
        join_none

        // Pin the model to RFC 8439 vectors.
        check("model_qr", qround(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567),
              128'hea2a92f4cb1cf8ce4581472e5881c4bb);
        blk = chacha_block(RFC_KEY, RFC_NONCE, 32'd1);
        check("model_blk_b0",  blk[511:384], 128'h10f1e7e4d13b5915500fdd1fa32071c4);
        check("model_blk_b16", blk[383:256], 128'hc7d1f4c733c068030422aa9ac3d46c4e);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", ks_if.ks_valid, 0);
        check("rst_data", ks_if.ks_data, 0);
        check("rst_fill", fill, 0);
        check("rst_ctr", ctr_cur, 0);
        check("rst_wrap", ctr_wrap, 0);
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        repeat (20) tick();
        check("no_valid_unconfigured", ks_if.ks_valid, 0);

        // Prefetch fill
        do_cfg(RFC_KEY, RFC_NONCE, 32'd1);
        n = 0;
        while (fill != 4 && n < 300) begin @(negedge clk); n++; end
        check("fill_reaches_depth", fill, 4);
        check("head_slice_literal", ks_if.ks_data, 128'h10f1e7e4d13b5915500fdd1fa32071c4);
        repeat (60) tick();
        check("fill_ctr_cur", ctr_cur, 5);
        check("fill_stays_full", fill, 4);

        // Streaming: a full buffer drains one slice per cycle
        s0 = slices_rx;
        ks_if.ks_ready = 1'b1;
        repeat (16) tick();
        check("stream_no_gap", slices_rx - s0, 16);
        n = 0;
        while (slices_rx < s0 + 32 && n < 300) begin tick(); n++; end
        check("stream_32_slices", slices_rx >= s0 + 32, 1);
        ks_if.ks_ready = 1'b0;

        // Backpressure
        b0 = blocks_rx;
        random_ready_until_blocks(b0 + 10, 3000);

        // Flush while a block is in flight and two are buffered
        do_cfg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom}, 32'h40);
        n = 0;
        while (!(fill == 2 && ctr_cur == 32'h43) && n < 300) begin @(negedge clk); n++; end
        check("flush_setup", (fill == 2) && (ctr_cur == 32'h43), 1);
        tick();
        b0 = blocks_rx;
        do_cfg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom}, 32'h100);
        random_ready_until_blocks(b0 + 3, 1500);

        // Counter wrap
        b0 = blocks_rx;
        do_cfg(RFC_KEY, {$urandom, $urandom, $urandom}, 32'hFFFF_FFFE);
`ifdef CHACHA_KS_WRAP_STOP_EN
        random_ready_until_blocks(b0 + 2, 1000);
        ks_if.ks_ready = 1'b1;
        repeat (80) tick();
        ks_if.ks_ready = 1'b0;
        check("wrap_two_blocks", blocks_rx - b0, 2);
        check("wrap_flag_set", ctr_wrap, 1);
        check("wrap_issue_stopped", ks_if.ks_valid, 0);
        check("wrap_ctr_cur", ctr_cur, 0);
`else
        random_ready_until_blocks(b0 + 3, 1500);
        check("wrap_flag_clear", ctr_wrap, 0);
`endif

        // Reset while a block is in flight
        do_cfg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom}, 32'd7);
        n = 0;
        while (!(fill == 3 && ctr_cur == 32'd11) && n < 300) begin @(negedge clk); n++; end
        check("rst_mid_setup", (fill == 3) && (ctr_cur == 32'd11), 1);
        tick();
        rst_n = 1'b0;
        cfg_gen++;
        #1;
        check("rst_mid_valid", ks_if.ks_valid, 0);
        check("rst_mid_data", ks_if.ks_data, 0);
        check("rst_mid_fill", fill, 0);
        check("rst_mid_ctr", ctr_cur, 0);
        check("rst_mid_wrap", ctr_wrap, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("post_rst_no_valid", ks_if.ks_valid, 0);
        check("post_rst_ctr", ctr_cur, 0);
        b0 = blocks_rx;
        do_cfg(RFC_KEY, RFC_NONCE, 32'd9);
        random_ready_until_blocks(b0 + 2, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
